arbiter: RTL and testbench

ARBITER -- requirements
Module: arbiter

---
 rtl/arbiter.sv | 98 +++++++++
 tb/tb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arbiter.sv
// Request arbiter: fixed-priority or round-robin selection with optional grant holding.
// All outputs are registered, so a grant appears on the edge after its request.
module arbiter #(
   parameter int PORTS                 = 4,
   parameter int ARB_TYPE_ROUND_ROBIN  = 0,
   parameter int ARB_BLOCK             = 0,
   parameter int ARB_BLOCK_ACK         = 1,
   parameter int ARB_LSB_HIGH_PRIORITY = 0,
   localparam int ENC_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] request,
   input  logic [PORTS-1:0] acknowledge,
   output logic [PORTS-1:0] grant,
   output logic             grant_valid,
   output logic [ENC_W-1:0] grant_encoded
);

   logic [PORTS-1:0] mask;
   logic [PORTS-1:0] mask_next;
   logic [PORTS-1:0] grant_next;
   logic             valid_next;
   logic [ENC_W-1:0] enc_next;
   logic [PORTS-1:0] masked_req;
   logic [PORTS-1:0] pick_src;
   logic [ENC_W-1:0] sel_idx;
   logic             req_hit;
   logic             ack_hit;
   logic             hold;
   logic             use_mask;

   // Index of the highest-priority set bit; the loop order makes the last hit win.
   function automatic logic [ENC_W-1:0] pick(input logic [PORTS-1:0] v);
      logic [ENC_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (ARB_LSB_HIGH_PRIORITY != 0) begin
            if (v[PORTS-1-i]) idx = ENC_W'(PORTS-1-i);
         end else begin
            if (v[i]) idx = ENC_W'(i);
         end
      end
      return idx;
   endfunction

   assign req_hit    = |(grant & request);
   assign ack_hit    = |(grant & acknowledge);
   assign hold       = (ARB_BLOCK != 0) &&
                       ((ARB_BLOCK_ACK != 0) ? (grant_valid && !ack_hit) : req_hit);
   assign masked_req = request & mask;
   assign use_mask   = (ARB_TYPE_ROUND_ROBIN != 0) && (|masked_req);
   assign pick_src   = use_mask ? masked_req : request;
   assign sel_idx    = pick(pick_src);

   // Release and re-arbitration share a cycle, so back-to-back grants need no idle gap.
   always_comb begin
      grant_next = grant;
      valid_next = grant_valid;
      enc_next   = grant_encoded;
      mask_next  = mask;
      if (!hold) begin
         if (|request) begin
            for (int i = 0; i < PORTS; i++) begin
               grant_next[i] = (sel_idx == ENC_W'(i));
            end
            valid_next = 1'b1;
            enc_next   = sel_idx;
            if (ARB_TYPE_ROUND_ROBIN != 0) begin
               if (ARB_LSB_HIGH_PRIORITY != 0) begin
                  mask_next = {PORTS{1'b1}} << (int'(sel_idx) + 1);
               end else begin
                  mask_next = {PORTS{1'b1}} >> (PORTS - int'(sel_idx));
               end
            end
         end else begin
            grant_next = '0;
            valid_next = 1'b0;
            enc_next   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant         <= '0;
         grant_valid   <= 1'b0;
         grant_encoded <= '0;
         mask          <= '0;
      end else begin
         grant         <= grant_next;
         grant_valid   <= valid_next;
         grant_encoded <= enc_next;
         mask          <= mask_next;
      end
   end

endmodule

// File: tb/tb_arbiter.sv
// Bench for arbiter: several configurations driven by directed stimulus,
// expected outputs queued at drive time and compared after the next edge.
module tb_arbiter;

   localparam int A  = 0;   // RR, block, release on ack, LSB high
   localparam int F1 = 1;   // fixed, non-blocking, LSB high
   localparam int F0 = 2;   // fixed, non-blocking, MSB high
   localparam int H  = 3;   // RR, block, release on request drop, LSB high
   localparam int R  = 4;   // RR, non-blocking, MSB high
   localparam int S  = 5;   // single port

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req_a = '0, ack_a = '0, req_f = '0, req_h = '0, req_r = '0, ack_z = '0;
   logic [0:0] req_s = '0, ack_s = '0;

   logic [3:0] g_a, g_f1, g_f0, g_h, g_r;
   logic       v_a, v_f1, v_f0, v_h, v_r, v_s;
   logic [1:0] e_a, e_f1, e_f0, e_h, e_r;
   logic [0:0] g_s, e_s;

   typedef struct {
      string      tag;
      int         id;
      logic [6:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
             .ARB_LSB_HIGH_PRIORITY(1)) u_a (
      .clk(clk), .rst(rst), .request(req_a), .acknowledge(ack_a),
      .grant(g_a), .grant_valid(v_a), .grant_encoded(e_a));

   arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
             .ARB_LSB_HIGH_PRIORITY(1)) u_f1 (
      .clk(clk), .rst(rst), .request(req_f), .acknowledge(ack_z),
      .grant(g_f1), .grant_valid(v_f1), .grant_encoded(e_f1));

   arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
             .ARB_LSB_HIGH_PRIORITY(0)) u_f0 (
      .clk(clk), .rst(rst), .request(req_f), .acknowledge(ack_z),
      .grant(g_f0), .grant_valid(v_f0), .grant_encoded(e_f0));

   arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
             .ARB_LSB_HIGH_PRIORITY(1)) u_h (
      .clk(clk), .rst(rst), .request(req_h), .acknowledge(ack_z),
      .grant(g_h), .grant_valid(v_h), .grant_encoded(e_h));

   arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
             .ARB_LSB_HIGH_PRIORITY(0)) u_r (
      .clk(clk), .rst(rst), .request(req_r), .acknowledge(ack_z),
      .grant(g_r), .grant_valid(v_r), .grant_encoded(e_r));

   arbiter #(.PORTS(1)) u_s (
      .clk(clk), .rst(rst), .request(req_s), .acknowledge(ack_s),
      .grant(g_s), .grant_valid(v_s), .grant_encoded(e_s));

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got grant=%b valid=%b enc=%0d, want grant=%b valid=%b enc=%0d",
                  tag, got[6:3], got[2], got[1:0], want[6:3], want[2], want[1:0]);
      end
   endtask

   function automatic logic [6:0] obs(input int id);
      case (id)
         A:       return {g_a, v_a, e_a};
         F1:      return {g_f1, v_f1, e_f1};
         F0:      return {g_f0, v_f0, e_f0};
         H:       return {g_h, v_h, e_h};
         R:       return {g_r, v_r, e_r};
         S:       return {3'b000, g_s, v_s, 1'b0, e_s};
         default: return 'x;
      endcase
   endfunction

   task automatic expect_out(input string tag, input int id, input logic [3:0] g,
                             input logic [1:0] e);
      exp_t x;
      x.tag = tag;
      x.id  = id;
      x.val = {g, |g, e};
      sb.push_back(x);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         check(x.tag, obs(x.id), x.val);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with all requests asserted
      req_a = 4'b1111;
      expect_out("rst_a0", A, 4'b0000, 2'd0); cyc();
      expect_out("rst_a1", A, 4'b0000, 2'd0); cyc();
      rst = 1'b1;
      expect_out("rst_release", A, 4'b0001, 2'd0); cyc();

      // Round-robin rotation with ack on each granted port
      ack_a = 4'b0001; expect_out("rr_1", A, 4'b0010, 2'd1); cyc();
      ack_a = 4'b0010; expect_out("rr_2", A, 4'b0100, 2'd2); cyc();
      ack_a = 4'b0100; expect_out("rr_3", A, 4'b1000, 2'd3); cyc();
      ack_a = 4'b1000; expect_out("rr_wrap", A, 4'b0001, 2'd0); cyc();
      ack_a = 4'b0000; expect_out("hold_noack", A, 4'b0001, 2'd0); cyc();

      // Hold until ack, foreign ack ignored
      req_a = 4'b0101; expect_out("hold_0101", A, 4'b0001, 2'd0); cyc();
      ack_a = 4'b0100; expect_out("ack_other", A, 4'b0001, 2'd0); cyc();
      ack_a = 4'b0001; expect_out("ack_release", A, 4'b0100, 2'd2); cyc();
      ack_a = 4'b0000; req_a = 4'b1100;
      expect_out("hold_1100", A, 4'b0100, 2'd2); cyc();

      // Asynchronous reset mid-grant, then unmasked restart
      #2 rst = 1'b0;
      #1 check("async_rst", obs(A), 7'b0000_0_00);
      expect_out("rst_mid", A, 4'b0000, 2'd0); cyc();
      rst = 1'b1;
      expect_out("rr_restart", A, 4'b0100, 2'd2); cyc();

      // Idle keeps the mask
      req_a = 4'b0000; ack_a = 4'b0100;
      expect_out("idle", A, 4'b0000, 2'd0); cyc();
      ack_a = 4'b0000; req_a = 4'b1010;
      expect_out("mask_kept", A, 4'b1000, 2'd3); cyc();
      ack_a = 4'b1000; req_a = 4'b0000;
      expect_out("idle2", A, 4'b0000, 2'd0); cyc();
      ack_a = 4'b0000;

      // Fixed priority, both directions
      req_f = 4'b0110;
      expect_out("fix_lsb_0110", F1, 4'b0010, 2'd1);
      expect_out("fix_msb_0110", F0, 4'b0100, 2'd2); cyc();
      req_f = 4'b1001;
      expect_out("fix_lsb_1001", F1, 4'b0001, 2'd0);
      expect_out("fix_msb_1001", F0, 4'b1000, 2'd3); cyc();
      req_f = 4'b1111;
      expect_out("fix_lsb_1111", F1, 4'b0001, 2'd0);
      expect_out("fix_msb_1111", F0, 4'b1000, 2'd3); cyc();
      req_f = 4'b0000;
      expect_out("fix_lsb_drop", F1, 4'b0000, 2'd0);
      expect_out("fix_msb_drop", F0, 4'b0000, 2'd0); cyc();

      // Hold on request
      req_h = 4'b0011; expect_out("hreq_0011", H, 4'b0001, 2'd0); cyc();
      req_h = 4'b0111; expect_out("hreq_hold", H, 4'b0001, 2'd0); cyc();
      req_h = 4'b0010; expect_out("hreq_move", H, 4'b0010, 2'd1); cyc();
      req_h = 4'b0011; expect_out("hreq_hold2", H, 4'b0010, 2'd1); cyc();
      req_h = 4'b0001; expect_out("hreq_back", H, 4'b0001, 2'd0); cyc();
      req_h = 4'b0000; expect_out("hreq_idle", H, 4'b0000, 2'd0); cyc();

      // Round-robin, MSB high, non-blocking
      req_r = 4'b1111;
      expect_out("rrm_3", R, 4'b1000, 2'd3); cyc();
      expect_out("rrm_2", R, 4'b0100, 2'd2); cyc();
      expect_out("rrm_1", R, 4'b0010, 2'd1); cyc();
      expect_out("rrm_0", R, 4'b0001, 2'd0); cyc();
      expect_out("rrm_wrap", R, 4'b1000, 2'd3); cyc();
      req_r = 4'b0101;
      expect_out("rrm_0101a", R, 4'b0100, 2'd2); cyc();
      expect_out("rrm_0101b", R, 4'b0001, 2'd0); cyc();
      req_r = 4'b0000;
      expect_out("rrm_idle", R, 4'b0000, 2'd0); cyc();

      // Single port
      req_s = 1'b1; expect_out("one_req", S, 4'b0001, 2'd0); cyc();
      req_s = 1'b0; expect_out("one_idle", S, 4'b0000, 2'd0); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
